// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types for the run/halt/single-step controller: run state, phase index and phase helpers.
// The optional breakpoint feature is selected with CPU_RUN_CTRL_BREAKPOINT_EN.
package cpu_run_ctrl_pkg;

    typedef enum logic [1:0] {
        HALTED = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2
    } run_state_e;

    typedef logic [1:0] phase_t;

    localparam phase_t PH_CYCLE = 2'd0;
    localparam phase_t PH_RAM   = 2'd1;
    localparam phase_t PH_INT   = 2'd2;

    function automatic phase_t next_phase(input phase_t p);
        phase_t n;
        case (p)
            PH_CYCLE: n = PH_RAM;
            PH_RAM:   n = PH_INT;
            default:  n = PH_CYCLE;
        endcase
        return n;
    endfunction

    // Strobe vector ordering is {cycle, ram, int}.
    function automatic logic [2:0] phase_onehot(input phase_t p);
        logic [2:0] s;
        case (p)
            PH_CYCLE: s = 3'b100;
            PH_RAM:   s = 3'b010;
            PH_INT:   s = 3'b001;
            default:  s = 3'b000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_phase_seq.sv
// Two-bit machine-cycle phase rotator with advance enable and synchronous restart,
// producing registered one-hot phase strobes.
module cpu_run_ctrl_phase_seq
    import cpu_run_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic advance_i,
    input  logic restart_i,
    input  logic active_i,
    output logic cycle_ph_o,
    output logic ram_ph_o,
    output logic int_ph_o
);

    phase_t     phase_q;
    phase_t     phase_d;
    logic [2:0] strobe_q;
    logic [2:0] strobe_d;

    always_comb begin
        phase_d = phase_q;
        if (restart_i) begin
            phase_d = PH_CYCLE;
        end else if (advance_i) begin
            phase_d = next_phase(phase_q);
        end
        // Strobes follow the phase being entered, so they appear on the same edge as the phase.
        strobe_d = active_i ? phase_onehot(phase_d) : 3'b000;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q  <= PH_CYCLE;
            strobe_q <= 3'b000;
        end else begin
            phase_q  <= phase_d;
            strobe_q <= strobe_d;
        end
    end

    assign cycle_ph_o = strobe_q[2];
    assign ram_ph_o   = strobe_q[1];
    assign int_ph_o   = strobe_q[0];

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step controller sequencing the three-phase machine cycle and counting completed cycles.
// Define CPU_RUN_CTRL_BREAKPOINT_EN to add the pc/bp_addr breakpoint ports and bp_hit.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             halt_req,
    input  logic             hlt_instr,
    input  logic             step_req,
    input  logic             cnt_clr,
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    input  logic [7:0]       bp_addr,
    input  logic             bp_valid,
    input  logic [7:0]       pc,
    output logic             bp_hit,
`endif
    output logic             cycle_ph,
    output logic             ram_ph,
    output logic             int_ph,
    output logic             running,
    output logic             halted,
    output logic             step_ack,
    output logic [CNT_W-1:0] cycle_count
);

    // Handshake: none; every input is a level sampled on the rising edge and every output is a register.
    run_state_e       state_q;
    run_state_e       state_d;
    logic             step_prev_q;
    logic             step_rise;
    logic             stop_at_int;
    logic             running_q;
    logic             halted_q;
    logic             step_ack_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    logic bp_pend_q;
    logic bp_hit_q;
    logic bp_match;

    assign bp_match = (state_q == RUN) && cycle_ph && bp_valid && (pc == bp_addr);
`endif

    assign step_rise = step_req && !step_prev_q;

    always_comb begin
        stop_at_int = halt_req || hlt_instr || !run;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
        stop_at_int = stop_at_int || bp_pend_q;
`endif
        state_d = state_q;
        case (state_q)
            HALTED: begin
                if (!halt_req) begin
                    if (run) begin
                        state_d = RUN;
                    end else if (step_rise) begin
                        state_d = STEP;
                    end
                end
            end
            // Requests only matter at the int phase, so a machine cycle is never cut short.
            RUN: begin
                if (int_ph && stop_at_int) begin
                    state_d = HALTED;
                end
            end
            STEP: begin
                if (int_ph) begin
                    state_d = HALTED;
                end
            end
            default: state_d = HALTED;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (cnt_clr) begin
            count_d = '0;
        end else if (int_ph) begin
            count_d = count_q + 1'b1;
        end
    end

    cpu_run_ctrl_phase_seq u_phase_seq (
        .clk        (clk),
        .reset      (reset),
        .advance_i  (state_q != HALTED),
        .restart_i  (state_q == HALTED),
        .active_i   (state_d != HALTED),
        .cycle_ph_o (cycle_ph),
        .ram_ph_o   (ram_ph),
        .int_ph_o   (int_ph)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= HALTED;
            step_prev_q <= 1'b0;
            running_q   <= 1'b0;
            halted_q    <= 1'b1;
            step_ack_q  <= 1'b0;
            count_q     <= '0;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
            bp_pend_q   <= 1'b0;
            bp_hit_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            step_prev_q <= step_req;
            running_q   <= (state_d != HALTED);
            halted_q    <= (state_d == HALTED);
            step_ack_q  <= (state_q == STEP) && int_ph;
            count_q     <= count_d;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
            // The match is remembered at cycle_ph and acted on when that machine cycle ends.
            if (state_d == HALTED) begin
                bp_pend_q <= 1'b0;
            end else if (bp_match) begin
                bp_pend_q <= 1'b1;
            end
            if ((state_q == RUN) && (state_d == HALTED)) begin
                bp_hit_q <= bp_pend_q;
            end else if (state_d != HALTED) begin
                bp_hit_q <= 1'b0;
            end
`endif
        end
    end

    assign running     = running_q;
    assign halted      = halted_q;
    assign step_ack    = step_ack_q;
    assign cycle_count = count_q;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    assign bp_hit      = bp_hit_q;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: vector table plus hand sequences for wrap, async reset and breakpoint.
module tb_cpu_run_ctrl;

    logic        clk;
    logic        reset;
    logic        run;
    logic        halt_req;
    logic        hlt_instr;
    logic        step_req;
    logic        cnt_clr;
    logic        cycle_ph, ram_ph, int_ph;
    logic        running, halted, step_ack;
    logic [15:0] cycle_count;
    logic        cycle_ph4, ram_ph4, int_ph4;
    logic        running4, halted4, step_ack4;
    logic [3:0]  cycle_count4;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    logic [7:0]  bp_addr;
    logic        bp_valid;
    logic [7:0]  pc;
    logic        bp_hit;
    logic        bp_hit4;
`endif

    int tests;
    int fails;

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    cpu_run_ctrl #(.CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .halt_req    (halt_req),
        .hlt_instr   (hlt_instr),
        .step_req    (step_req),
        .cnt_clr     (cnt_clr),
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
        .bp_addr     (bp_addr),
        .bp_valid    (bp_valid),
        .pc          (pc),
        .bp_hit      (bp_hit),
`endif
        .cycle_ph    (cycle_ph),
        .ram_ph      (ram_ph),
        .int_ph      (int_ph),
        .running     (running),
        .halted      (halted),
        .step_ack    (step_ack),
        .cycle_count (cycle_count)
    );

    cpu_run_ctrl #(.CNT_W(4)) dut4 (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .halt_req    (halt_req),
        .hlt_instr   (hlt_instr),
        .step_req    (step_req),
        .cnt_clr     (cnt_clr),
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
        .bp_addr     (bp_addr),
        .bp_valid    (bp_valid),
        .pc          (pc),
        .bp_hit      (bp_hit4),
`endif
        .cycle_ph    (cycle_ph4),
        .ram_ph      (ram_ph4),
        .int_ph      (int_ph4),
        .running     (running4),
        .halted      (halted4),
        .step_ack    (step_ack4),
        .cycle_count (cycle_count4)
    );

    typedef struct {
        logic        rst_n;
        logic        run;
        logic        halt;
        logic        hlt;
        logic        step;
        logic        clr;
        logic [2:0]  ph;
        logic        running;
        logic        halted;
        logic        ack;
        logic [15:0] cnt;
    } vec_t;

    localparam int NVEC = 48;
    localparam logic [2:0] Z = 3'b000;
    localparam logic [2:0] C = 3'b100;
    localparam logic [2:0] R = 3'b010;
    localparam logic [2:0] I = 3'b001;

    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic rst_n, input logic r, input logic h, input logic hi,
                                input logic s, input logic c, input logic [2:0] ph,
                                input logic rn, input logic hl, input logic ack, input int cnt);
        vec_t v;
        v.rst_n = rst_n; v.run = r; v.halt = h; v.hlt = hi; v.step = s; v.clr = c;
        v.ph = ph; v.running = rn; v.halted = hl; v.ack = ack; v.cnt = cnt[15:0];
        return v;
    endfunction

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst_n, input logic r, input logic h, input logic hi,
                         input logic s, input logic c);
        reset = rst_n; run = r; halt_req = h; hlt_instr = hi; step_req = s; cnt_clr = c;
    endtask

    // Scoreboard
    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic check_strobes(input string name, input int idx, input logic [2:0] exp);
        check(name, idx, {29'd0, cycle_ph, ram_ph, int_ph}, {29'd0, exp});
        check({name, "_w4"}, idx, {29'd0, cycle_ph4, ram_ph4, int_ph4}, {29'd0, exp});
    endtask

    initial begin
        tests = 0;
        fails = 0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
        bp_addr  = 8'h05;
        bp_valid = 1'b0;
        pc       = 8'h00;
`endif

        //                 rst run hlt hli stp clr  ph run hlt ack cnt
        vecs[0]  = mk(1'b0, 0, 0, 0, 0, 0, Z, 0, 1, 0, 0);
        vecs[1]  = mk(1'b1, 1, 0, 0, 0, 0, C, 1, 0, 0, 0);
        vecs[2]  = mk(1'b1, 1, 0, 0, 0, 0, R, 1, 0, 0, 0);
        vecs[3]  = mk(1'b1, 1, 0, 0, 0, 0, I, 1, 0, 0, 0);
        vecs[4]  = mk(1'b1, 1, 0, 0, 0, 0, C, 1, 0, 0, 1);
        vecs[5]  = mk(1'b1, 1, 1, 0, 0, 0, R, 1, 0, 0, 1);
        vecs[6]  = mk(1'b1, 1, 0, 0, 0, 0, I, 1, 0, 0, 1);
        vecs[7]  = mk(1'b1, 1, 0, 0, 0, 0, C, 1, 0, 0, 2);
        vecs[8]  = mk(1'b1, 1, 0, 0, 0, 0, R, 1, 0, 0, 2);
        vecs[9]  = mk(1'b1, 1, 1, 0, 0, 0, I, 1, 0, 0, 2);
        vecs[10] = mk(1'b1, 1, 1, 0, 0, 0, Z, 0, 1, 0, 3);
        vecs[11] = mk(1'b1, 0, 1, 0, 0, 0, Z, 0, 1, 0, 3);
        vecs[12] = mk(1'b1, 0, 0, 0, 0, 0, Z, 0, 1, 0, 3);
        vecs[13] = mk(1'b1, 1, 0, 0, 0, 0, C, 1, 0, 0, 3);
        vecs[14] = mk(1'b1, 1, 0, 0, 0, 0, R, 1, 0, 0, 3);
        vecs[15] = mk(1'b1, 1, 0, 1, 0, 0, I, 1, 0, 0, 3);
        vecs[16] = mk(1'b1, 1, 0, 1, 0, 0, Z, 0, 1, 0, 4);
        vecs[17] = mk(1'b1, 0, 0, 0, 0, 0, Z, 0, 1, 0, 4);
        vecs[18] = mk(1'b1, 1, 0, 0, 0, 0, C, 1, 0, 0, 4);
        vecs[19] = mk(1'b1, 1, 0, 0, 0, 0, R, 1, 0, 0, 4);
        vecs[20] = mk(1'b1, 0, 0, 0, 0, 0, I, 1, 0, 0, 4);
        vecs[21] = mk(1'b1, 0, 0, 0, 0, 0, Z, 0, 1, 0, 5);
        vecs[22] = mk(1'b1, 0, 0, 0, 1, 0, C, 1, 0, 0, 5);
        vecs[23] = mk(1'b1, 0, 0, 0, 1, 0, R, 1, 0, 0, 5);
        vecs[24] = mk(1'b1, 1, 1, 0, 1, 0, I, 1, 0, 0, 5);
        vecs[25] = mk(1'b1, 0, 0, 0, 1, 0, Z, 0, 1, 1, 6);
        vecs[26] = mk(1'b1, 0, 0, 0, 1, 0, Z, 0, 1, 0, 6);
        vecs[27] = mk(1'b1, 0, 0, 0, 0, 0, Z, 0, 1, 0, 6);
        vecs[28] = mk(1'b1, 0, 0, 0, 1, 0, C, 1, 0, 0, 6);
        vecs[29] = mk(1'b1, 0, 0, 0, 1, 0, R, 1, 0, 0, 6);
        vecs[30] = mk(1'b1, 0, 0, 0, 1, 0, I, 1, 0, 0, 6);
        vecs[31] = mk(1'b1, 0, 0, 0, 1, 0, Z, 0, 1, 1, 7);
        vecs[32] = mk(1'b1, 0, 0, 0, 0, 0, Z, 0, 1, 0, 7);
        vecs[33] = mk(1'b1, 0, 0, 0, 0, 1, Z, 0, 1, 0, 0);
        vecs[34] = mk(1'b1, 1, 0, 0, 0, 0, C, 1, 0, 0, 0);
        vecs[35] = mk(1'b1, 1, 0, 0, 0, 0, R, 1, 0, 0, 0);
        vecs[36] = mk(1'b1, 1, 0, 0, 0, 0, I, 1, 0, 0, 0);
        vecs[37] = mk(1'b1, 1, 0, 0, 0, 1, C, 1, 0, 0, 0);
        vecs[38] = mk(1'b1, 1, 0, 0, 0, 0, R, 1, 0, 0, 0);
        vecs[39] = mk(1'b1, 1, 0, 0, 0, 0, I, 1, 0, 0, 0);
        vecs[40] = mk(1'b1, 0, 0, 0, 0, 0, Z, 0, 1, 0, 1);
        vecs[41] = mk(1'b1, 1, 1, 0, 1, 0, Z, 0, 1, 0, 1);
        vecs[42] = mk(1'b1, 0, 0, 0, 0, 0, Z, 0, 1, 0, 1);
        vecs[43] = mk(1'b1, 1, 0, 0, 0, 0, C, 1, 0, 0, 1);
        vecs[44] = mk(1'b1, 1, 0, 0, 0, 0, R, 1, 0, 0, 1);
        vecs[45] = mk(1'b1, 1, 1, 1, 0, 0, I, 1, 0, 0, 1);
        vecs[46] = mk(1'b1, 1, 1, 1, 0, 0, Z, 0, 1, 0, 2);
        vecs[47] = mk(1'b1, 0, 0, 0, 0, 0, Z, 0, 1, 0, 2);

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].rst_n, vecs[i].run, vecs[i].halt, vecs[i].hlt, vecs[i].step, vecs[i].clr);
            tick();
            check_strobes("strobes", i, vecs[i].ph);
            check("running", i, {31'd0, running}, {31'd0, vecs[i].running});
            check("halted", i, {31'd0, halted}, {31'd0, vecs[i].halted});
            check("step_ack", i, {31'd0, step_ack}, {31'd0, vecs[i].ack});
            check("count", i, {16'd0, cycle_count}, {16'd0, vecs[i].cnt});
            check("count_w4", i, {28'd0, cycle_count4}, {28'd0, vecs[i].cnt[3:0]});
        end

        // 17 machine cycles from a cleared counter: 16-bit reaches 17, 4-bit wraps to 1.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check("clr_before_wrap", 0, {16'd0, cycle_count}, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 51; i++) begin
            tick();
            check_strobes("wrap_strobes", i, (i % 3 == 0) ? C : ((i % 3 == 1) ? R : I));
            if (i == 30) begin
                check("count_after_10", i, {16'd0, cycle_count}, 32'd10);
            end
        end
        run = 1'b0;
        tick();
        check("wrap_halted", 0, {31'd0, halted}, 32'd1);
        check("wrap_count16", 0, {16'd0, cycle_count}, 32'd17);
        check("wrap_count4", 0, {28'd0, cycle_count4}, 32'd1);
        tick();
        check("count_stable_halted", 0, {16'd0, cycle_count}, 32'd17);

        // Asynchronous reset in the middle of a machine cycle.
        run = 1'b1;
        tick();
        tick();
        check_strobes("pre_reset_ram", 0, R);
        reset = 1'b0;
        #2;
        check_strobes("async_reset_strobes", 0, Z);
        check("async_reset_halted", 0, {31'd0, halted}, 32'd1);
        check("async_reset_running", 0, {31'd0, running}, 32'd0);
        check("async_reset_count", 0, {16'd0, cycle_count}, 32'd0);
        run = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check("post_reset_halted", 0, {31'd0, halted}, 32'd1);
        check_strobes("post_reset_strobes", 0, Z);

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
        // pc advances at each new cycle_ph: 3, 4, 5; the machine stops after the cycle at pc 5.
        bp_addr  = 8'h05;
        bp_valid = 1'b1;
        pc       = 8'h02;
        run      = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (cycle_ph) pc = pc + 8'h01;
            check("bp_no_early_halt", i, {31'd0, running}, 32'd1);
        end
        tick();
        check("bp_halted", 0, {31'd0, halted}, 32'd1);
        check("bp_hit_set", 0, {31'd0, bp_hit}, 32'd1);
        check("bp_count", 0, {16'd0, cycle_count}, 32'd3);
        check_strobes("bp_strobes", 0, Z);
        pc = 8'h06;
        tick();
        check("bp_rerun_running", 0, {31'd0, running}, 32'd1);
        check("bp_hit_cleared", 0, {31'd0, bp_hit}, 32'd0);
        run = 1'b0;
        tick();
        tick();
        tick();
        check("bp_stop_halted", 0, {31'd0, halted}, 32'd1);
        check("bp_hit_after_run_stop", 0, {31'd0, bp_hit}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/halt/single-step controller that sequences the CPU's three-phase machine cycle (cycle, ram, internal). It issues one-hot phase strobes to the datapath, starts and stops execution only on machine-cycle boundaries, services single-step requests, and keeps a machine-cycle counter. It sits between the front-panel/debug inputs and the CPU core, replacing free-running phase generation with controlled sequencing.

## Interface
- CNT_W, 16, width of the completed-machine-cycle counter
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- run  in  1  level; request continuous execution
- halt_req  in  1  level; request stop at next cycle boundary
- hlt_instr  in  1  level from decoder; HLT instruction executing, sampled during internal phase
- step_req  in  1  level; request exactly one machine cycle
- cnt_clr  in  1  synchronous clear of cycle_count
- cycle_ph  out  1  phase 0 strobe (fetch/cycle)
- ram_ph  out  1  phase 1 strobe (memory access)
- int_ph  out  1  phase 2 strobe (internal/execute)
- running  out  1  high in RUN or STEP
- halted  out  1  high in HALTED
- step_ack  out  1  one-clk pulse when a step completes
- cycle_count  out  CNT_W  completed machine cycles

## Operation
- States: HALTED, RUN, STEP. Phase index PH_CYCLE=0, PH_RAM=1, PH_INT=2, advancing 0→1→2→0 one per clk while running.
- Reset (reset=0): state HALTED, phase PH_CYCLE, all strobes 0, running=0, halted=1, step_ack=0, cycle_count=0. Takes effect immediately, mid-cycle included; no partial cycle is completed.
- HALTED: strobes all 0. Priority among requests: halt_req > run > step_req. run=1 and halt_req=0 → RUN. step_req=1, run=0, halt_req=0 → STEP. step_req is edge-qualified: a step starts only on a 0→1 transition of step_req seen in HALTED.
- RUN: strobes rotate continuously. At the clk where int_ph=1, if halt_req=1 or hlt_instr=1 or run=0 → HALTED next clk; otherwise next phase is PH_CYCLE. Requests arriving during PH_CYCLE/PH_RAM are only evaluated at PH_INT; a halt_req pulse deasserted before PH_INT is ignored.
- STEP: exactly one cycle_ph, ram_ph, int_ph sequence, then HALTED; step_ack=1 on the first HALTED clk. run/halt_req during STEP have no effect until HALTED.
- cycle_count: +1 at each clk with int_ph=1, wraps from 2^CNT_W−1 to 0. cnt_clr=1 forces 0 and wins over a simultaneous increment.
- Exactly one strobe high whenever running=1; none when halted=1. running and halted are mutually exclusive and complementary.

## Timing
- All outputs registered.
- HALTED→RUN: run sampled high at edge N; running=1 and cycle_ph=1 after edge N+1... specifically state and cycle_ph update together at edge N+1 (one-clk latency).
- Machine cycle = 3 clks; continuous run gives cycle_ph every 3rd clk.
- Stop latency: halt request high at the int_ph clk → halted=1 and all strobes 0 at next edge. Worst case from request to halted: 3 clks.
- Step: step_req edge at edge N → cycle_ph at N+1, ram_ph N+2, int_ph N+3, halted and step_ack at N+4, step_ack low at N+5.
- hlt_instr and halt_req simultaneous: single stop, identical timing.

## Configuration
- CPU_RUN_CTRL_BREAKPOINT_EN: adds inputs bp_addr (8 bits), bp_valid (1), pc (8). When defined, in RUN, if bp_valid=1 and pc==bp_addr during cycle_ph, a breakpoint flag sets; the machine completes that cycle and goes HALTED after int_ph, plus output bp_hit (registered, 1 while halted on breakpoint, cleared on leaving HALTED). Breakpoint does not trigger in STEP. When undefined, ports and logic are absent; behaviour otherwise identical.

## Structure
- Package cpu_run_ctrl_pkg: state enum (HALTED, RUN, STEP), phase constants PH_CYCLE/PH_RAM/PH_INT, phase index typedef (2 bits).
- Sub-module phase_seq: 2-bit phase rotator with advance enable and synchronous restart to PH_CYCLE, decoded to the three one-hot strobes; the control FSM and counter stay in cpu_run_ctrl.

## Test plan
- Reset release, run=1 → cycle_ph at clk 1, ram_ph clk 2, int_ph clk 3, repeating; after 10 cycles cycle_count=10.
- RUN, halt_req asserted during ram_ph and held → halts after that int_ph, strobes 0, halted=1, count unchanged afterwards.
- HALTED, step_req rising edge → exactly one 3-phase sequence, step_ack one clk, cycle_count +1; held step_req does not restart.
- CNT_W=4, run 17 cycles → cycle_count wraps to 1; cnt_clr coinciding with int_ph → count 0.
- reset low during ram_ph → all strobes 0 immediately, halted=1; run, halt_req, step_req asserted together in HALTED → stays HALTED.
- With CPU_RUN_CTRL_BREAKPOINT_EN, bp_addr=0x05, pc reaches 0x05 → halts after that cycle, bp_hit=1; run again → bp_hit=0.
